// File: rtl/keypad_encoder.sv
// Debounced 10-key keypad to BCD encoder with a one-cycle active-low load strobe per accepted key.
// Optional feature: define KEYPAD_ENCODER_DIGIT_LIMIT_EN to stop accepting keys after three digits until clr.
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] keys,
  output logic [3:0] data,
  output logic       load,
  output logic       key_held,
  output logic       full
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    PRESS,
    WAIT_RELEASE,
    RELEASE_DEBOUNCE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       cand, cand_nxt;
  logic [9:0]       sync_p0, sync_p1;
  logic [3:0]       ks_code;
  logic             ks_idle;
  logic             ks_valid;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  // Stage p0/p1: two-flop synchronizer on the raw key lines
  always_ff @(posedge clk) begin
    if (clr) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= keys;
      sync_p1 <= sync_p0;
    end
  end

  // Pattern classification on the synchronized vector
  always_comb begin
    ks_code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (sync_p1[i]) ks_code = 4'(i);
    end
  end

  assign ks_idle  = (sync_p1 == 10'd0);
  assign ks_valid = !ks_idle && ((sync_p1 & (sync_p1 - 10'd1)) == 10'd0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    unique case (state)
      IDLE: begin
        if (ks_valid && !full) begin
          state_nxt = DEBOUNCE;
          cand_nxt  = ks_code;
          cnt_nxt   = CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (ks_valid && (ks_code == cand)) begin
          if (cnt >= CNT_MAX) state_nxt = PRESS;
          else                cnt_nxt   = cnt_sat_inc(cnt);
        end else if (ks_valid) begin
          cand_nxt = ks_code;
          cnt_nxt  = CNT_ONE;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      PRESS: begin
        state_nxt = WAIT_RELEASE;
        cnt_nxt   = '0;
      end
      WAIT_RELEASE: begin
        if (ks_idle) begin
          state_nxt = RELEASE_DEBOUNCE;
          cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE_DEBOUNCE: begin
        if (!ks_idle) begin
          state_nxt = WAIT_RELEASE;
          cnt_nxt   = '0;
        end else if (cnt >= CNT_MAX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_sat_inc(cnt);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Stage p2: FSM state and the output digit register
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= 4'd0;
      data  <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
      if (state_nxt == PRESS) data <= cand;
    end
  end

  assign load     = (state != PRESS);
  assign key_held = (state == PRESS) || (state == WAIT_RELEASE);

`ifdef KEYPAD_ENCODER_DIGIT_LIMIT_EN
  logic [1:0] digit_cnt;

  // Counts on entry to PRESS so full rises together with the third strobe
  always_ff @(posedge clk) begin
    if (clr) begin
      digit_cnt <= 2'd0;
    end else if ((state_nxt == PRESS) && (digit_cnt != 2'd3)) begin
      digit_cnt <= digit_cnt + 2'd1;
    end
  end

  assign full = (digit_cnt == 2'd3);
`else
  assign full = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: directed scenarios plus random key activity,
// compared every cycle against a run-length reference model of the debounce rules.
`timescale 1ns/1ps
module tb_keypad_encoder;

  localparam int D = 4;
`ifdef KEYPAD_ENCODER_DIGIT_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic [9:0] keys;
  logic [3:0] data;
  logic       load;
  logic       key_held;
  logic       full;

  always #5 clk = ~clk;

  keypad_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .clr      (clr),
    .keys     (keys),
    .data     (data),
    .load     (load),
    .key_held (key_held),
    .full     (full)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int strobes  = 0;
  int last_strobe_cyc = -1;

  // Reference model: sync pipeline, then mode 0 = seeking a key, 1 = strobe cycle, 2 = awaiting release
  logic [9:0] m_s0, m_s1;
  int         m_mode, m_run, m_zrun, m_digits;
  logic [9:0] m_pat;
  logic [3:0] m_data;
  bit         m_strobe;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] key_index(input logic [9:0] v);
    logic [3:0] r = 4'd0;
    for (int i = 0; i < 10; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  task automatic model_edge(input logic [9:0] k, input logic c);
    logic [9:0] ks;
    bit is_full;
    m_strobe = 1'b0;
    if (c) begin
      m_s0 = '0; m_s1 = '0; m_mode = 0; m_run = 0; m_zrun = 0;
      m_pat = '0; m_data = 4'd0; m_digits = 0;
    end else begin
      ks = m_s1;
      is_full = LIMIT && (m_digits >= 3);
      case (m_mode)
        0: begin
          if (!is_full && $countones(ks) == 1) begin
            if (m_run > 0 && ks == m_pat) m_run++;
            else begin m_run = 1; m_pat = ks; end
            if (m_run == D + 1) begin
              m_strobe = 1'b1;
              m_mode = 1;
              m_run = 0;
              m_data = key_index(ks);
              if (m_digits < 3) m_digits++;
            end
          end else begin
            m_run = 0;
          end
        end
        1: begin m_mode = 2; m_zrun = 0; end
        default: begin
          if (ks == 10'd0) begin
            m_zrun++;
            if (m_zrun == D + 1) begin m_mode = 0; m_run = 0; end
          end else begin
            m_zrun = 0;
          end
        end
      endcase
      m_s1 = m_s0;
      m_s0 = k;
    end
  endtask

  task automatic step(input logic [9:0] k, input logic c);
    keys = k;
    clr  = c;
    @(posedge clk);
    model_edge(k, c);
    #1;
    cyc++;
    check_val("load", 32'(load), 32'(!m_strobe));
    check_val("data", 32'(data), 32'(m_data));
    check_val("key_held", 32'(key_held), 32'((m_mode == 1) || (m_mode == 2 && m_zrun == 0)));
    check_val("full", 32'(full), 32'(LIMIT && (m_digits >= 3)));
    if (load === 1'b0) begin
      strobes++;
      last_strobe_cyc = cyc;
    end
  endtask

  task automatic hold(input logic [9:0] k, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b0);
  endtask

  task automatic press_digit(input int d, input int n);
    hold(10'(1 << d), n);
  endtask

  initial begin
    int base, s0;
    logic [9:0] k;
    keys = 10'h3FF;
    clr  = 1'b1;

    // Reset with every key pressed
    step(10'h3FF, 1'b1);
    step(10'h3FF, 1'b1);
    check_val("rst_load", 32'(load), 32'd1);
    check_val("rst_data", 32'(data), 32'd0);
    hold(10'h3FF, 5);
    hold(10'd0, 6);
    check_val("rst_no_strobe", 32'(strobes), 32'd0);

    // Clean press of key 5
    strobes = 0; base = cyc;
    press_digit(5, 20);
    check_val("clean_count", 32'(strobes), 32'd1);
    check_val("clean_edge", 32'(last_strobe_cyc - base), 32'(D + 3));
    check_val("clean_data", 32'(data), 32'd5);
    check_val("clean_held", 32'(key_held), 32'd1);
    hold(10'd0, 12);
    check_val("clean_released", 32'(key_held), 32'd0);

    // Bouncing key 4
    strobes = 0;
    step(10'h010, 1'b0); step(10'h000, 1'b0); step(10'h010, 1'b0); step(10'h000, 1'b0);
    base = cyc;
    hold(10'h010, 12);
    check_val("bounce_count", 32'(strobes), 32'd1);
    check_val("bounce_edge", 32'(last_strobe_cyc - base), 32'(D + 3));
    check_val("bounce_data", 32'(data), 32'd4);
    hold(10'd0, 12);

    // Two keys together, then release one
    strobes = 0;
    hold(10'h084, 15);
    check_val("multi_none", 32'(strobes), 32'd0);
    base = cyc;
    hold(10'h004, 12);
    check_val("multi_count", 32'(strobes), 32'd1);
    check_val("multi_edge", 32'(last_strobe_cyc - base), 32'(D + 3));
    check_val("multi_data", 32'(data), 32'd2);
    hold(10'd0, 12);

    // Digit sequence after a clean start
    step(10'd0, 1'b1);
    hold(10'd0, 3);
    strobes = 0;
    press_digit(5, 10); check_val("seq_d0", 32'(data), 32'd5); hold(10'd0, 12);
    press_digit(4, 10); check_val("seq_d1", 32'(data), 32'd4); hold(10'd0, 12);
    press_digit(3, 10); check_val("seq_d2", 32'(data), 32'd3); hold(10'd0, 12);
    check_val("seq_count", 32'(strobes), 32'd3);
    press_digit(1, 10); hold(10'd0, 12);
`ifdef KEYPAD_ENCODER_DIGIT_LIMIT_EN
    check_val("limit_count", 32'(strobes), 32'd3);
    check_val("limit_full", 32'(full), 32'd1);
    check_val("limit_data", 32'(data), 32'd3);
`else
    check_val("nolimit_count", 32'(strobes), 32'd4);
    check_val("nolimit_data", 32'(data), 32'd1);
`endif
    step(10'd0, 1'b1);
    strobes = 0;
    press_digit(1, 10);
    check_val("after_clr_count", 32'(strobes), 32'd1);
    check_val("after_clr_data", 32'(data), 32'd1);
    check_val("after_clr_full", 32'(full), 32'd0);
    hold(10'd0, 12);

    // Reset in the middle of debouncing key 9
    strobes = 0;
    hold(10'h200, 3);
    step(10'h200, 1'b1);
    base = cyc;
    hold(10'h200, 12);
    check_val("midrst_count", 32'(strobes), 32'd1);
    check_val("midrst_edge", 32'(last_strobe_cyc - base), 32'(D + 3));
    check_val("midrst_data", 32'(data), 32'd9);
    hold(10'd0, 12);

    // Random activity against the model
    for (int it = 0; it < 300; it++) begin
      int sel, len;
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 24) == 0) step(10'(($urandom)), 1'b1);
      case (sel)
        0, 1, 2: k = 10'd0;
        3, 4, 5, 6: k = 10'(1 << $urandom_range(0, 9));
        7: begin
          s0 = $urandom_range(0, 9);
          k = 10'(1 << s0) | 10'(1 << ((s0 + 1 + $urandom_range(0, 8)) % 10));
        end
        8: k = 10'($urandom);
        default: k = 10'(1 << $urandom_range(0, 9));
      endcase
      if (sel == 9) begin
        for (int j = 0; j < len; j++) step((j % 2) ? 10'd0 : k, 1'b0);
      end else begin
        hold(k, len);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
